// File: rtl/ftoi_arbiter.sv
// ftoi_arbiter: shares one ftoi converter among N_REQ requesters with round-robin grant and id tracking.
// Define FTOI_ARB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, no rr pointer).
module ftoi_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LAT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_op,
    output logic [N_REQ-1:0]    req_ready,
    output logic [31:0]         cv_op,
    input  logic [31:0]         cv_result,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [31:0]         resp_data,
    input  logic                flush,
    output logic                flush_done,
    output logic                busy
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
    state_t          state, state_nx;
    logic            gnt_any, hs;
    logic [ID_W-1:0] gnt_id;
    logic [31:0]     gnt_op;
    logic [LAT:0]    tag_v;
    logic [ID_W-1:0] tag_id [LAT+1];
`ifndef FTOI_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0] rr_ptr;
    int              idx;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        gnt_op  = '0;
`ifdef FTOI_ARB_FIXED_PRIO_EN
        for (int j = 0; j < N_REQ; j++)
            if (!gnt_any && req_valid[j]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(j);
                gnt_op  = req_op[32*j +: 32];
            end
`else
        idx = 0;
        // search upward from rr_ptr, wrapping at N_REQ-1
        for (int j = 0; j < N_REQ; j++) begin
            idx = (int'(rr_ptr) + j) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(idx);
                gnt_op  = req_op[32*idx +: 32];
            end
        end
`endif
        hs        = gnt_any && (state == RUN);
        req_ready = '0;
        if (hs) req_ready[gnt_id] = 1'b1;
        state_nx = (state == RUN)   ? (flush ? DRAIN : RUN) :
                   (state == DRAIN) ? (|tag_v ? DRAIN : DONE) : RUN;
    end

    assign flush_done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            cv_op      <= '0;
            tag_v      <= '0;
            for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            busy       <= 1'b0;
`ifndef FTOI_ARB_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            state     <= state_nx;
            cv_op     <= hs ? gnt_op : '0;
            tag_v     <= {tag_v[LAT-1:0], hs};
            tag_id[0] <= gnt_id;
            for (int i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
            // the last tag stage lines up with cv_result for the op it describes
            resp_valid <= tag_v[LAT] ? (N_REQ'(1) << tag_id[LAT]) : '0;
            if (tag_v[LAT]) resp_data <= cv_result;
            busy <= |{tag_v[LAT-1:0], hs};
`ifndef FTOI_ARB_FIXED_PRIO_EN
            if (hs) rr_ptr <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_ftoi_arbiter.sv
// tb_ftoi_arbiter: directed stimulus with a scoreboard queue and a decoupled response monitor.
module tb_ftoi_arbiter;
    logic         clk = 0, reset = 0, flush = 0;
    logic [3:0]   req_valid = 0, req_ready, resp_valid;
    logic [127:0] req_op = 0;
    logic [31:0]  cv_op, cv_result = 0, resp_data, s1 = 0;
    logic         flush_done, busy;
    int           passed = 0, total = 0, cyc = 0, base;

    typedef struct {logic [3:0] id; logic [31:0] data; int at;} exp_t;
    exp_t sb [$];

    ftoi_arbiter dut (.clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
                      .req_ready(req_ready), .cv_op(cv_op), .cv_result(cv_result),
                      .resp_valid(resp_valid), .resp_data(resp_data), .flush(flush),
                      .flush_done(flush_done), .busy(busy));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // floor-rounding float-to-int model of the shared converter, two cycles deep
    function automatic logic [31:0] ftoi(input logic [31:0] f);
        int e;
        logic [31:0] m, q;
        logic rem;
        if (f[30:23] == 0) return 32'd0;
        e = int'(f[30:23]) - 127;
        m = {8'd1, f[22:0]};
        if (e < 0) begin q = 0; rem = 1; end
        else if (e <= 23) begin q = m >> (23 - e); rem = (m & ((32'd1 << (23 - e)) - 1)) != 0; end
        else begin q = m << (e - 23); rem = 0; end
        return f[31] ? -q - {31'd0, rem} : q;
    endfunction

    always @(posedge clk) begin
        s1        <= ftoi(cv_op);
        cv_result <= s1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (resp_valid !== 4'b0) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_resp: got resp_valid=%b expected none at cycle %0d", resp_valid, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", {28'd0, resp_valid}, {28'd0, e.id});
                chk("resp_data", resp_data, e.data);
                chk("resp_cycle", cyc, e.at);
            end
        end
    end

    task automatic set_op(input int i, input logic [31:0] v);
        req_op[32*i +: 32] = v;
    endtask

    // called just after a rising edge; a grant here completes at the next edge
    task automatic step(input logic [3:0] vld, input logic [3:0] rdy, input logic [31:0] res, input string nm);
        req_valid = vld;
        #1;
        chk(nm, {28'd0, req_ready}, {28'd0, rdy});
        if (rdy != 0) sb.push_back('{rdy, res, cyc + 4});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        req_valid = 0; flush = 0; reset = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic drain(input string nm);
        req_valid = 0;
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        @(posedge clk); #1;
        chk(nm, sb.size(), 0);
    endtask

    initial begin
        #7;
        chk("rst_cv_op", cv_op, 0);
        chk("rst_resp", {27'd0, resp_valid, busy}, 0);
        chk("rst_flush_done", {31'd0, flush_done}, 0);
        do_reset();
        @(posedge clk); #1;

        // 1: single op 3.0 -> 3
        set_op(0, 32'h40400000);
        step(4'b0001, 4'b0001, 32'h00000003, "t1_grant");
        drain("t1_drain");

`ifdef FTOI_ARB_FIXED_PRIO_EN
        // 6: fixed priority, requester 3 starves
        do_reset();
        set_op(3, 32'h40800000);
        for (int k = 0; k < 5; k++) step(4'b1001, 4'b0001, 32'h00000003, "t6_grant");
        drain("t6_drain");
`else
        // 2: all four request continuously from reset
        do_reset();
        set_op(0, 32'h3F800000); set_op(1, 32'h40000000);
        set_op(2, 32'h40400000); set_op(3, 32'h40800000);
        step(4'b1111, 4'b0001, 32'd1, "t2_grant0");
        step(4'b1111, 4'b0010, 32'd2, "t2_grant1");
        step(4'b1111, 4'b0100, 32'd3, "t2_grant2");
        step(4'b1111, 4'b1000, 32'd4, "t2_grant3");
        step(4'b1111, 4'b0001, 32'd1, "t2_grant4");
        step(4'b1111, 4'b0010, 32'd2, "t2_grant5");
        drain("t2_drain");
`endif

        // 3: -2.5 -> -3, 0.5 -> 0
        do_reset();
        set_op(1, 32'hC0200000); set_op(2, 32'h3F000000);
        step(4'b0110, 4'b0010, 32'hFFFFFFFD, "t3_grant1");
        step(4'b0100, 4'b0100, 32'h00000000, "t3_grant2");
        drain("t3_drain");

        // 4: flush with the second issue, then drain and resume
        do_reset();
        set_op(0, 32'h40400000); set_op(1, 32'hC0200000);
        set_op(2, 32'h3F000000); set_op(3, 32'h40800000);
        step(4'b0001, 4'b0001, 32'h00000003, "t4_grant0");
        flush = 1;
        step(4'b0010, 4'b0010, 32'hFFFFFFFD, "t4_grant1");
        flush = 0;
        req_valid = 4'b1111;
        base = cyc;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_ready_drain", {28'd0, req_ready}, 0);
            chk("t4_flush_done", {31'd0, flush_done}, {31'd0, cyc == base + 4});
            chk("t4_busy", {31'd0, busy}, {31'd0, cyc < base + 3});
            @(posedge clk); #1;
        end
`ifdef FTOI_ARB_FIXED_PRIO_EN
        step(4'b1111, 4'b0001, 32'h00000003, "t4_resume");
`else
        step(4'b1111, 4'b0100, 32'h00000000, "t4_resume");
`endif
        drain("t4_drain");

        // 5: async reset with two ops in flight drops them
        set_op(0, 32'h40400000); set_op(1, 32'h40000000);
        step(4'b0001, 4'b0001, 32'h00000003, "t5_grant0");
        step(4'b0010, 4'b0010, 32'h00000002, "t5_grant1");
        req_valid = 0;
        #2 reset = 0;
        #1;
        sb.delete();
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_resp_valid", {28'd0, resp_valid}, 0);
        chk("t5_cv_op", cv_op, 0);
        chk("t5_resp_data", resp_data, 0);
        chk("t5_outs", {27'd0, req_ready, flush_done}, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        repeat (6) @(posedge clk);
        #1;
        chk("t5_quiet", {27'd0, resp_valid, busy}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
